// File: rtl/igmp_rx_parser_if.sv
// Word stream into the IGMP receive parser: 32-bit words with valid/ready and end-of-message.
interface igmp_rx_parser_if;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        s_last;

  modport master (output s_valid, output s_data, output s_last, input s_ready);
  modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/igmp_rx_parser.sv
// Streaming IGMP receive parser: decodes v3 Query, v2 Report and Leave messages, captures up to
// MAX_SRC query sources, and reports a per-message verdict, error code and saturating counters.
// Optional feature: define IGMP_CSUM_CHECK_EN to verify the ones'-complement message checksum.
module igmp_rx_parser #(
  parameter int unsigned MAX_SRC   = 8,
  parameter int unsigned SRC_IDX_W = 3,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  igmp_rx_parser_if.slave      s_if,
  output logic                 done,
  output logic                 msg_valid,
  output logic                 msg_invalid,
  output logic [2:0]           err_code,
  output logic                 is_query,
  output logic                 is_report,
  output logic                 is_leave,
  output logic [7:0]           type_o,
  output logic [7:0]           mrc_o,
  output logic [15:0]          csum_o,
  output logic [31:0]          group_o,
  output logic                 s_flag,
  output logic [2:0]           qrv_o,
  output logic [7:0]           qqic_o,
  output logic [15:0]          nsrc_o,
  input  logic [SRC_IDX_W-1:0] src_idx,
  output logic [31:0]          src_addr,
  output logic [CNT_W-1:0]     good_cnt,
  output logic [CNT_W-1:0]     bad_cnt
);

  typedef enum logic [2:0] {StIdle, StW1, StW2, StSrc, StDrain, StVerdict} state_e;

  typedef struct packed {
    logic [7:0]  typ;
    logic [7:0]  mrc;
    logic [15:0] csum;
    logic [31:0] group;
    logic        s;
    logic [2:0]  qrv;
    logic [7:0]  qqic;
    logic [15:0] nsrc;
  } fields_t;

  localparam logic [7:0] TypeQuery  = 8'h11;
  localparam logic [7:0] TypeReport = 8'h16;
  localparam logic [7:0] TypeLeave  = 8'h17;

  localparam logic [2:0] ErrNone  = 3'd0;
  localparam logic [2:0] ErrType  = 3'd1;
  localparam logic [2:0] ErrNsrc  = 3'd2;
  localparam logic [2:0] ErrShort = 3'd3;
  localparam logic [2:0] ErrLong  = 3'd4;
  localparam logic [2:0] ErrGroup = 3'd6;

  state_e               state_q, state_d;
  fields_t              fld_q, fld_d, out_q, out_d;
  logic [2:0]           err_q, err_d, err_code_q, err_code_d, verdict_err;
  logic [SRC_IDX_W-1:0] src_cnt_q, src_cnt_d;
  logic                 done_q, done_d, valid_q, valid_d, invalid_q, invalid_d;
  logic [2:0]           kind_q, kind_d;  // {query, report, leave}
  logic [CNT_W-1:0]     good_q, good_d, bad_q, bad_d;
  logic                 src_we, xfer, last, grp_ok;
  logic [31:0]          data;
  logic [31:0]          src_mem_q [MAX_SRC];
  logic [31:0]          src_addr_q;

  assign xfer          = s_if.s_valid && s_if.s_ready;
  assign s_if.s_ready  = (state_q != StVerdict);
  assign data          = s_if.s_data;
  assign last          = s_if.s_last;

`ifdef IGMP_CSUM_CHECK_EN
  localparam logic [2:0] ErrCsum = 3'd5;
  logic [15:0] acc_q, acc_d;

  function automatic logic [15:0] ones_add(logic [15:0] a, logic [15:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[15:0] + {15'd0, sum[16]};
  endfunction

  // Checksum accumulator restarts with the first word of each message.
  always_comb begin
    acc_d = acc_q;
    if (xfer) acc_d = ones_add(ones_add((state_q == StIdle) ? 16'h0 : acc_q, data[31:16]),
                               data[15:0]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign verdict_err = (err_q == ErrNone && acc_q != 16'hFFFF) ? ErrCsum : err_q;
`else
  assign verdict_err = err_q;
`endif

  // Parse FSM next state, field capture and verdict update.
  always_comb begin
    state_d    = state_q;
    fld_d      = fld_q;
    err_d      = err_q;
    src_cnt_d  = src_cnt_q;
    src_we     = 1'b0;
    out_d      = out_q;
    err_code_d = err_code_q;
    done_d     = 1'b0;
    valid_d    = valid_q;
    invalid_d  = invalid_q;
    kind_d     = kind_q;
    good_d     = good_q;
    bad_d      = bad_q;
    // Queries may also carry the all-zero general group.
    grp_ok     = (data[31:28] == 4'hE) || (fld_q.typ == TypeQuery && data == 32'h0);
    unique case (state_q)
      StIdle: if (xfer) begin
        fld_d      = '0;
        fld_d.typ  = data[31:24];
        fld_d.mrc  = data[23:16];
        fld_d.csum = data[15:0];
        err_d      = ErrNone;
        if (!(data[31:24] inside {TypeQuery, TypeReport, TypeLeave})) begin
          err_d   = ErrType;
          state_d = last ? StVerdict : StDrain;
        end else if (last) begin
          err_d   = ErrShort;
          state_d = StVerdict;
        end else begin
          state_d = StW1;
        end
      end
      StW1: if (xfer) begin
        fld_d.group = data;
        if (!grp_ok) begin
          err_d   = ErrGroup;
          state_d = last ? StVerdict : StDrain;
        end else if (fld_q.typ != TypeQuery) begin
          if (!last) err_d = ErrLong;
          state_d = last ? StVerdict : StDrain;
        end else if (last) begin
          err_d   = ErrShort;
          state_d = StVerdict;
        end else begin
          state_d = StW2;
        end
      end
      StW2: if (xfer) begin
        fld_d.s    = data[27];
        fld_d.qrv  = data[26:24];
        fld_d.qqic = data[23:16];
        fld_d.nsrc = data[15:0];
        src_cnt_d  = '0;
        if (data[15:0] > 16'(MAX_SRC)) begin
          err_d   = ErrNsrc;
          state_d = last ? StVerdict : StDrain;
        end else if (data[15:0] == 16'h0) begin
          if (!last) err_d = ErrLong;
          state_d = last ? StVerdict : StDrain;
        end else if (last) begin
          err_d   = ErrShort;
          state_d = StVerdict;
        end else begin
          state_d = StSrc;
        end
      end
      StSrc: if (xfer) begin
        src_we = 1'b1;
        if (16'(src_cnt_q) == fld_q.nsrc - 16'd1) begin
          if (!last) err_d = ErrLong;
          state_d = last ? StVerdict : StDrain;
        end else if (last) begin
          err_d   = ErrShort;
          state_d = StVerdict;
        end else begin
          src_cnt_d = src_cnt_q + SRC_IDX_W'(1);
        end
      end
      StDrain: if (xfer && last) state_d = StVerdict;
      StVerdict: begin
        done_d     = 1'b1;
        out_d      = fld_q;
        err_code_d = verdict_err;
        valid_d    = (verdict_err == ErrNone);
        invalid_d  = (verdict_err != ErrNone);
        kind_d     = (verdict_err == ErrNone) ?
                     {fld_q.typ == TypeQuery, fld_q.typ == TypeReport, fld_q.typ == TypeLeave} :
                     3'b000;
        if (verdict_err == ErrNone) begin
          if (good_q != '1) good_d = good_q + CNT_W'(1);
        end else begin
          if (bad_q != '1) bad_d = bad_q + CNT_W'(1);
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Parser state, working fields and presented results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      fld_q      <= '0;
      out_q      <= '0;
      err_q      <= '0;
      err_code_q <= '0;
      src_cnt_q  <= '0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
      invalid_q  <= 1'b0;
      kind_q     <= '0;
      good_q     <= '0;
      bad_q      <= '0;
    end else begin
      state_q    <= state_d;
      fld_q      <= fld_d;
      out_q      <= out_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      src_cnt_q  <= src_cnt_d;
      done_q     <= done_d;
      valid_q    <= valid_d;
      invalid_q  <= invalid_d;
      kind_q     <= kind_d;
      good_q     <= good_d;
      bad_q      <= bad_d;
    end
  end

  // Source store and its registered read port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(MAX_SRC); i++) src_mem_q[i] <= '0;
      src_addr_q <= '0;
    end else begin
      if (src_we) src_mem_q[src_cnt_q] <= data;
      src_addr_q <= (32'(src_idx) < MAX_SRC) ? src_mem_q[src_idx] : '0;
    end
  end

  assign done        = done_q;
  assign msg_valid   = valid_q;
  assign msg_invalid = invalid_q;
  assign err_code    = err_code_q;
  assign is_query    = kind_q[2];
  assign is_report   = kind_q[1];
  assign is_leave    = kind_q[0];
  assign type_o      = out_q.typ;
  assign mrc_o       = out_q.mrc;
  assign csum_o      = out_q.csum;
  assign group_o     = out_q.group;
  assign s_flag      = out_q.s;
  assign qrv_o       = out_q.qrv;
  assign qqic_o      = out_q.qqic;
  assign nsrc_o      = out_q.nsrc;
  assign src_addr    = src_addr_q;
  assign good_cnt    = good_q;
  assign bad_cnt     = bad_q;

endmodule

// File: tb/tb_igmp_rx_parser.sv
// Self-checking bench for igmp_rx_parser: directed vectors plus randomized messages checked
// against a message-level reference model. Honors IGMP_CSUM_CHECK_EN like the design.
module tb_igmp_rx_parser;
  localparam int unsigned MaxSrc  = 8;
  localparam int unsigned SrcIdxW = 3;
  localparam int unsigned CntW    = 4;
  localparam int          CntMax  = (1 << CntW) - 1;

  logic clk = 1'b0;
  logic rst_n;
  logic done, msg_valid, msg_invalid, is_query, is_report, is_leave, s_flag;
  logic [2:0] err_code, qrv_o;
  logic [7:0] type_o, mrc_o, qqic_o;
  logic [15:0] csum_o, nsrc_o;
  logic [31:0] group_o, src_addr;
  logic [SrcIdxW-1:0] src_idx;
  logic [CntW-1:0] good_cnt, bad_cnt;

  igmp_rx_parser_if bus ();

  igmp_rx_parser #(.MAX_SRC(MaxSrc), .SRC_IDX_W(SrcIdxW), .CNT_W(CntW)) dut (
    .clk(clk), .rst_n(rst_n), .s_if(bus), .done(done), .msg_valid(msg_valid),
    .msg_invalid(msg_invalid), .err_code(err_code), .is_query(is_query), .is_report(is_report),
    .is_leave(is_leave), .type_o(type_o), .mrc_o(mrc_o), .csum_o(csum_o), .group_o(group_o),
    .s_flag(s_flag), .qrv_o(qrv_o), .qqic_o(qqic_o), .nsrc_o(nsrc_o), .src_idx(src_idx),
    .src_addr(src_addr), .good_cnt(good_cnt), .bad_cnt(bad_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  err;
    logic [7:0]  typ;
    logic [7:0]  mrc;
    logic [15:0] csum;
    logic [31:0] grp;
    logic        s;
    logic [2:0]  qrv;
    logic [7:0]  qqic;
    logic [15:0] nsrc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mw[$];
  logic [31:0] mem [MaxSrc];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          m_good  = 0;
  int          m_bad   = 0;
  logic        prev_done = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Ones'-complement sum of every 16-bit half of the current message.
  function automatic logic [15:0] onesum();
    int unsigned s = 0;
    foreach (mw[i]) begin
      s += 32'(mw[i][31:16]);
      if (s > 32'hFFFF) s -= 32'hFFFF;
      s += 32'(mw[i][15:0]);
      if (s > 32'hFFFF) s -= 32'hFFFF;
    end
    return s[15:0];
  endfunction

  task automatic fix_csum();
    logic [31:0] w0 = mw[0];
    w0[15:0] = 16'h0;
    mw[0] = w0;
    w0[15:0] = ~onesum();
    mw[0] = w0;
  endtask

  // Expected verdict of a whole message, derived from its word list and length.
  task automatic model_push();
    exp_t e = '0;
    int   n = mw.size();
    bit   gok;
    e.typ  = mw[0][31:24];
    e.mrc  = mw[0][23:16];
    e.csum = mw[0][15:0];
    if (!(e.typ inside {8'h11, 8'h16, 8'h17})) e.err = 3'd1;
    else if (n < 2) e.err = 3'd3;
    else begin
      e.grp = mw[1];
      gok = (mw[1][31:28] == 4'hE) || (e.typ == 8'h11 && mw[1] == 32'h0);
      if (!gok) e.err = 3'd6;
      else if (e.typ != 8'h11) begin
        if (n > 2) e.err = 3'd4;
      end else if (n < 3) e.err = 3'd3;
      else begin
        e.s    = mw[2][27];
        e.qrv  = mw[2][26:24];
        e.qqic = mw[2][23:16];
        e.nsrc = mw[2][15:0];
        if (int'(e.nsrc) > int'(MaxSrc)) e.err = 3'd2;
        else begin
          for (int i = 0; i < int'(e.nsrc) && 3 + i < n; i++) mem[i] = mw[3 + i];
          if (n < 3 + int'(e.nsrc)) e.err = 3'd3;
          else if (n > 3 + int'(e.nsrc)) e.err = 3'd4;
        end
      end
    end
`ifdef IGMP_CSUM_CHECK_EN
    if (e.err == 3'd0 && onesum() != 16'hFFFF) e.err = 3'd5;
`endif
    exp_q.push_back(e);
  endtask

  task automatic send_msg(input bit gaps);
    int w;
    model_push();
    foreach (mw[i]) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        bus.s_valid = 1'b0;
        repeat ($urandom_range(1, 2)) @(negedge clk);
      end
      bus.s_valid = 1'b1;
      bus.s_data  = mw[i];
      bus.s_last  = (i == mw.size() - 1);
      if (i > 0) check("ready_mid", 32'(bus.s_ready), 32'd1);
      w = 0;
      while (!bus.s_ready) begin
        @(negedge clk);
        w++;
        if (w > 20) begin
          check("ready_wait", 32'(bus.s_ready), 32'd1);
          break;
        end
      end
      @(posedge clk);
      @(negedge clk);
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (exp_q.size() != 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("done_wait", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
  endtask

  task automatic check_src();
    for (int k = 0; k < 3; k++) begin
      int unsigned idx;
      idx = $urandom_range(0, MaxSrc - 1);
      src_idx = SrcIdxW'(idx);
      @(negedge clk);
      check("src_rd", src_addr, mem[idx]);
    end
  endtask

  task automatic gen_rand();
    logic [7:0]  t;
    logic [31:0] w;
    int          r, ns, n;
    mw.delete();
    r = $urandom_range(0, 9);
    t = (r == 0) ? 8'($urandom) : (r < 5) ? 8'h11 : (r < 7) ? 8'h16 : 8'h17;
    mw.push_back({t, 8'($urandom), 16'h0});
    r = $urandom_range(0, 9);
    w = {4'hE, 28'($urandom)};
    if (r == 0) w = $urandom;
    else if (r == 1) w = 32'h0;
    mw.push_back(w);
    if (t == 8'h11) begin
      ns = ($urandom_range(0, 7) == 0) ? $urandom_range(MaxSrc + 1, MaxSrc + 3)
                                       : $urandom_range(0, MaxSrc);
      mw.push_back({16'($urandom), 16'(ns)});
      for (int i = 0; i < ns; i++) mw.push_back($urandom);
    end
    r = $urandom_range(0, 9);
    if (r == 0 && mw.size() > 1) begin
      n = $urandom_range(1, mw.size() - 1);
      while (mw.size() > n) void'(mw.pop_back());
    end else if (r == 1) begin
      repeat ($urandom_range(1, 2)) mw.push_back($urandom);
    end
    fix_csum();
    if ($urandom_range(0, 7) == 0) begin
      w = mw[0];
      w[15:0] = w[15:0] ^ 16'($urandom_range(1, 65535));
      mw[0] = w;
    end
  endtask

  // Every done pulse is compared with the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_good = 0;
      m_bad  = 0;
    end else if (done) begin
      check("done_pulse", 32'(prev_done), 32'd0);
      if (exp_q.size() == 0) check("spurious_done", 32'(done), 32'd0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.err == 3'd0) begin
          if (m_good < CntMax) m_good++;
        end else if (m_bad < CntMax) m_bad++;
        check("err_code", 32'(err_code), 32'(e.err));
        check("verdict", 32'({msg_valid, msg_invalid}), (e.err == 3'd0) ? 32'd2 : 32'd1);
        check("kind", 32'({is_query, is_report, is_leave}),
              (e.err != 3'd0) ? 32'd0 : (e.typ == 8'h11) ? 32'd4 : (e.typ == 8'h16) ? 32'd2 : 32'd1);
        check("hdr", {type_o, mrc_o, csum_o}, {e.typ, e.mrc, e.csum});
        check("group", group_o, e.grp);
        check("qfields", {4'b0, s_flag, qrv_o, qqic_o, nsrc_o}, {4'b0, e.s, e.qrv, e.qqic, e.nsrc});
        check("counts", 32'({good_cnt, bad_cnt}), 32'({CntW'(m_good), CntW'(m_bad)}));
      end
    end
    prev_done = done;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    src_idx     = '0;
    for (int i = 0; i < int'(MaxSrc); i++) mem[i] = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_flags", 32'({done, msg_valid, msg_invalid, err_code, is_query, is_report, is_leave,
                            s_flag, qrv_o}), 32'd0);
    check("rst_hdr", {type_o, mrc_o, csum_o}, 32'd0);
    check("rst_group", group_o, 32'd0);
    check("rst_qqic_nsrc", 32'({qqic_o, nsrc_o}), 32'd0);
    check("rst_cnt", 32'({good_cnt, bad_cnt}), 32'd0);
    check("rst_src", src_addr, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", 32'(bus.s_ready), 32'd1);

    mw = {32'h1164E41E, 32'h00000000, 32'h0A7D0000};
    send_msg(1'b0);
    wait_idle();
    check("q_kind", 32'({msg_valid, is_query}), 32'd3);
    check("q_fields", {4'b0, s_flag, qrv_o, qqic_o, nsrc_o}, {4'b0, 1'b1, 3'd2, 8'h7D, 16'd0});
    check("q_good", 32'(good_cnt), 32'd1);

    mw = {32'h1600F8FA, 32'hEF010203};
    send_msg(1'b0);
    wait_idle();
    check("r_kind", 32'({msg_valid, is_report}), 32'd3);
    check("r_group", group_o, 32'hEF010203);

    mw = {32'h17000000, 32'h0A000001};
    fix_csum();
    send_msg(1'b0);
    wait_idle();
    check("l_err", 32'({msg_invalid, err_code}), 32'({1'b1, 3'd6}));
    check("l_bad", 32'(bad_cnt), 32'd1);

    mw = {32'h11000000, 32'hE0000001, 32'h00000009};
    for (int i = 0; i < 9; i++) mw.push_back($urandom);
    fix_csum();
    send_msg(1'b0);
    mw = {32'h16000000, 32'hE1020304};
    fix_csum();
    send_msg(1'b0);
    wait_idle();
    check("after_nsrc9", 32'({msg_valid, err_code}), 32'({1'b1, 3'd0}));

    mw = {32'h11000000, 32'h00000000, 32'h00000002, 32'hC0A80001, 32'hC0A80002};
    fix_csum();
    send_msg(1'b0);
    wait_idle();
    src_idx = SrcIdxW'(1);
    @(negedge clk);
    check("src_idx1", src_addr, 32'hC0A80002);

    mw = {32'h1600F8FB, 32'hEF010203};
    send_msg(1'b0);
    wait_idle();
`ifdef IGMP_CSUM_CHECK_EN
    check("csum_err", 32'(err_code), 32'd5);
`else
    check("csum_err", 32'(err_code), 32'd0);
`endif

    for (int k = 0; k < 150; k++) begin
      gen_rand();
      send_msg(1'b1);
      if ($urandom_range(0, 1) == 0) begin
        wait_idle();
        check_src();
      end
    end
    wait_idle();
    check_src();

    // Abandon a query partway through its sources.
    mw = {32'h11000000, 32'hE0000005, 32'h00000004, 32'hAAAA0001, 32'hAAAA0002};
    foreach (mw[i]) begin
      bus.s_valid = 1'b1;
      bus.s_data  = mw[i];
      bus.s_last  = 1'b0;
      @(posedge clk);
      @(negedge clk);
    end
    bus.s_valid = 1'b0;
    src_idx = '0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_flags", 32'({done, msg_valid, msg_invalid, err_code, is_query, is_report,
                                is_leave}), 32'd0);
    check("mid_rst_cnt", 32'({good_cnt, bad_cnt}), 32'd0);
    check("mid_rst_group", group_o, 32'd0);
    check("mid_rst_src", src_addr, 32'd0);
    exp_q.delete();
    for (int i = 0; i < int'(MaxSrc); i++) mem[i] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_src();

    mw = {32'h1164E41E, 32'h00000000, 32'h0A7D0000};
    send_msg(1'b0);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
